// File: rtl/aes_pkg.sv
// Shared constants, state encoding and the round-0 load helper for the
// iterative AES-128 round sequencer.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned AES_BLK_W  = 128;
    localparam int unsigned TAGGED_W   = 129;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Round 0 is a bare AddRoundKey; the tag bit rides along untouched.
    function automatic logic [TAGGED_W-1:0] round0_load(
        input logic [TAGGED_W-1:0] din,
        input aes_blk_t            key
    );
        return {din[TAGGED_W-1], din[AES_BLK_W-1:0] ^ key};
    endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: time-multiplexes an external standard-round and
// final-round datapath over the state register, with valid/ready on both sides.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_IDX_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [TAGGED_W-1:0]  in_data,
    output logic [KEY_IDX_W-1:0] key_idx,
    input  logic [AES_BLK_W-1:0] key_in,
    output logic [TAGGED_W-1:0]  round_in,
    input  logic [TAGGED_W-1:0]  std_out,
    input  logic [TAGGED_W-1:0]  fin_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TAGGED_W-1:0]  out_data,
    output logic                 busy
);

    localparam logic [KEY_IDX_W-1:0] LAST_STD = KEY_IDX_W'(NUM_ROUNDS - 1);
    localparam logic [KEY_IDX_W-1:0] FIN_IDX  = KEY_IDX_W'(NUM_ROUNDS);
    localparam logic [KEY_IDX_W-1:0] ONE      = KEY_IDX_W'(1);

    seq_state_t           r_fsm;
    seq_state_t           w_fsm_nxt;
    logic [KEY_IDX_W-1:0] r_cnt;
    logic [KEY_IDX_W-1:0] w_cnt_nxt;
    logic [TAGGED_W-1:0]  r_state;
    logic [TAGGED_W-1:0]  w_state_nxt;
    logic                 w_accept;
    logic                 w_unused_tags;

    // The datapaths' own tag bits are meaningless; the captured tag is kept instead.
    assign w_unused_tags = std_out[TAGGED_W-1] ^ fin_out[TAGGED_W-1];

    assign in_ready  = (r_fsm == IDLE) || ((r_fsm == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign key_idx   = ((r_fsm == ROUND) || (r_fsm == FINAL)) ? r_cnt : '0;
    assign round_in  = r_state;
    assign out_data  = r_state;
    assign out_valid = (r_fsm == DONE);
    assign busy      = (r_fsm != IDLE);

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        unique case (r_fsm)
            IDLE: begin
                if (w_accept) begin
                    w_fsm_nxt   = ROUND;
                    w_cnt_nxt   = ONE;
                    w_state_nxt = round0_load(in_data, key_in);
                end
            end
            ROUND: begin
                w_state_nxt = {r_state[TAGGED_W-1], std_out[AES_BLK_W-1:0]};
                if (r_cnt == LAST_STD) begin
                    w_fsm_nxt = FINAL;
                    w_cnt_nxt = FIN_IDX;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            FINAL: begin
                w_state_nxt = {r_state[TAGGED_W-1], fin_out[AES_BLK_W-1:0]};
                w_fsm_nxt   = DONE;
            end
            DONE: begin
                // Handing off the result and accepting the next block share one cycle.
                if (out_ready) begin
                    if (in_valid) begin
                        w_fsm_nxt   = ROUND;
                        w_cnt_nxt   = ONE;
                        w_state_nxt = round0_load(in_data, key_in);
                    end else begin
                        w_fsm_nxt = IDLE;
                        w_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                w_fsm_nxt = IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_cnt   <= '0;
            r_state <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: behavioural AES round datapaths and key ROM
// around the sequencer, a vector table, and a cycle-accurate scoreboard.
module tb_aes_round_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [128:0] in_data;
    logic [3:0]   key_idx;
    logic [127:0] key_in;
    logic [128:0] round_in;
    logic [128:0] std_out;
    logic [128:0] fin_out;
    logic         out_valid;
    logic         out_ready;
    logic [128:0] out_data;
    logic         busy;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from first principles: GF(2^8) inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r    = 8'h01;
        logic [7:0] base = x;
        logic [7:0] e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic mix);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = b[r + 4*((c + r) % 4)];
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    // Round key i lives at bits [i*128 +: 128].
    function automatic logic [11*128-1:0] key_expand(input logic [127:0] key);
        logic [31:0]        w [44];
        logic [31:0]        tmp;
        logic [7:0]         rc = 8'h01;
        logic [11*128-1:0]  ks;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])}
                      ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) ks[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [11*128-1:0] ks;
        logic [127:0]      s;
        ks = key_expand(key);
        s  = pt ^ ks[127:0];
        for (int r = 1; r < 10; r++) s = aes_round(s, ks[r*128 +: 128], 1'b1);
        return aes_round(s, ks[10*128 +: 128], 1'b0);
    endfunction

    // Key-schedule ROM and both round datapaths; datapath tag bits are deliberately corrupted.
    logic [11*128-1:0] sched;
    assign key_in  = (key_idx <= 4'd10) ? sched[int'(key_idx)*128 +: 128] : '0;
    assign std_out = {~round_in[128], aes_round(round_in[127:0], key_in, 1'b1)};
    assign fin_out = {~round_in[128], aes_round(round_in[127:0], key_in, 1'b0)};

    aes_round_sequencer #(
        .NUM_ROUNDS (10),
        .KEY_IDX_W  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_idx   (key_idx),
        .key_in    (key_in),
        .round_in  (round_in),
        .std_out   (std_out),
        .fin_out   (fin_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, expected event", name);
    endtask

    // Scoreboard: expected ciphertext and acceptance cycle per accepted block.
    typedef struct {
        logic [128:0] exp;
        int           acc;
    } sb_t;
    sb_t          sb[$];
    logic [128:0] cur_exp;
    logic         prev_ov = 1'b0;
    int           age;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() == 0) begin
                chk("idle_in_ready", 129'(in_ready), 129'(1));
                chk("idle_busy", 129'(busy), 129'(0));
                chk("idle_out_valid", 129'(out_valid), 129'(0));
                chk("idle_key_idx", 129'(key_idx), 129'(0));
            end else begin
                age = cyc - sb[0].acc;
                chk("out_valid", 129'(out_valid), 129'(age >= 11));
                chk("busy", 129'(busy), 129'(1));
                chk("key_idx", 129'(key_idx), 129'((age <= 10) ? age : 0));
                chk("in_ready", 129'(in_ready), 129'((age >= 11) && out_ready));
                if (out_valid && !prev_ov) chk("latency", 129'(age), 129'(11));
                if (out_valid) chk("out_data", out_data, sb[0].exp);
                if (out_valid && out_ready) void'(sb.pop_front());
            end
            if (in_valid && in_ready) sb.push_back('{cur_exp, cyc});
        end
        prev_ov = out_valid;
    end

    task automatic send(input logic [128:0] d, input logic [128:0] e, output logic was_done);
        bit ok = 1'b0;
        was_done = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        cur_exp  = e;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok       = 1'b1;
                was_done = out_valid;
                break;
            end
        end
        if (!ok) fail_timeout("accept");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_timeout("drain");
    endtask

    typedef struct {
        logic [127:0] key;
        logic [128:0] din;
        logic [128:0] exp;
    } vec_t;
    vec_t vecs [5];

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         dummy;
    logic [127:0] rkey;
    logic [127:0] rpt;
    logic         rtag;

    initial begin
        vecs[0] = '{K1, {1'b0, P1}, {1'b0, C1}};
        vecs[1] = '{K1, {1'b1, P1}, {1'b1, C1}};
        vecs[2] = '{K2, {1'b0, P2}, {1'b0, C2}};
        for (int i = 3; i < 5; i++) begin
            rkey    = {$urandom(), $urandom(), $urandom(), $urandom()};
            rpt     = {$urandom(), $urandom(), $urandom(), $urandom()};
            rtag    = 1'($urandom_range(0, 1));
            vecs[i] = '{rkey, {rtag, rpt}, {rtag, aes_encrypt(rkey, rpt)}};
        end

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cur_exp   = '0;
        sched     = key_expand(K1);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 129'(out_valid), 129'(0));
        chk("rst_in_ready", 129'(in_ready), 129'(1));
        chk("rst_busy", 129'(busy), 129'(0));
        chk("rst_key_idx", 129'(key_idx), 129'(0));
        chk("rst_out_data", out_data, 129'(0));
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            sched = key_expand(vecs[i].key);
            send(vecs[i].din, vecs[i].exp, dummy);
            wait_idle();
        end

        // Output backpressure: DONE must hold still while out_ready is low.
        sched     = key_expand(K2);
        out_ready = 1'b0;
        send({1'b1, P2}, {1'b1, C2}, dummy);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (out_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) fail_timeout("bp_out_valid");
        end
        repeat (20) @(negedge clk);
        chk("bp_held_ov", 129'(out_valid), 129'(1));
        chk("bp_held_in_ready", 129'(in_ready), 129'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_ov", 129'(out_valid), 129'(0));
        wait_idle();

        // Back-to-back: second block held on the input during the first.
        sched = key_expand(K1);
        send({1'b0, P1}, {1'b0, C1}, dummy);
        send({1'b1, P1}, {1'b1, C1}, dummy);
        chk("b2b_no_gap", 129'(dummy), 129'(1));
        wait_idle();

        // Reset in round 5 discards the block; a fresh block still encrypts correctly.
        send({1'b0, P1}, {1'b0, C1}, dummy);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_key_idx", 129'(key_idx), 129'(5));
        rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", 129'(out_valid), 129'(0));
        chk("mid_rst_in_ready", 129'(in_ready), 129'(1));
        chk("mid_rst_busy", 129'(busy), 129'(0));
        chk("mid_rst_key_idx", 129'(key_idx), 129'(0));
        chk("mid_rst_out_data", out_data, 129'(0));
        @(posedge clk); #1;
        rst   = 1'b0;
        sched = key_expand(K2);
        send({1'b0, P2}, {1'b0, C2}, dummy);
        wait_idle();

        // in_valid pulsed mid-block must be ignored.
        sched = key_expand(K1);
        send({1'b1, P1}, {1'b1, C1}, dummy);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = {1'b0, P2};
        cur_exp  = {1'b0, C2};
        @(negedge clk);
        chk("held_off_in_ready", 129'(in_ready), 129'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

endmodule
